// File: rtl/id_hazard_scheduler_if.sv
// Decode-stage hazard bundle: decoded operand/destination fields in, forwarding
// selects plus stall/bubble/syscall controls out.
interface id_hazard_scheduler_if #(
  parameter int unsigned REG_BITS = 5
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic [REG_BITS-1:0] id_dest;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_syscall;

  logic [1:0]          sel_a;
  logic [1:0]          sel_b;
  logic                stall;
  logic                bubble;
  logic                sys_pulse;
  logic [31:0]         stall_cycles;

  // Decode side drives instruction fields and consumes hazard decisions.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output id_dest, id_reg_write, id_mem_read, id_syscall,
    input  sel_a, sel_b, stall, bubble, sys_pulse, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  id_dest, id_reg_write, id_mem_read, id_syscall,
    output sel_a, sel_b, stall, bubble, sys_pulse, stall_cycles
  );
endinterface

// File: rtl/id_hazard_scheduler.sv
// Decode hazard scheduler: EXE/MEM destination shadows, forwarding selects, load-use
// stalls and the syscall drain/signal/release sequence. HAZ_PERF_COUNT_EN adds a stall counter.
module id_hazard_scheduler #(
  parameter int unsigned SYS_DRAIN_CYCLES = 4,
  parameter int unsigned REG_BITS         = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  id_hazard_scheduler_if.slave  hz
);

  localparam logic [3:0] DrainLoad = 4'(SYS_DRAIN_CYCLES - 1);
  localparam bit         SkipDrain = (SYS_DRAIN_CYCLES <= 1);

  typedef enum logic [1:0] {StIdle, StDrain, StSignal, StRelease} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                sys_pulse_q, sys_pulse_d;

  logic [REG_BITS-1:0] exe_dest_q, exe_dest_d, mem_dest_q, mem_dest_d;
  logic                exe_wr_q, exe_wr_d, mem_wr_q, mem_wr_d;
  logic                exe_ld_q, exe_ld_d, mem_ld_q, mem_ld_d;

  logic                exe_rs, exe_rt, mem_rs, mem_rt;
  logic                load_use, sys_trig, fsm_stall, stall;
  logic [1:0]          sel_a, sel_b;

  function automatic logic src_match(input logic uses, input logic wr,
                                     input logic [REG_BITS-1:0] dest,
                                     input logic [REG_BITS-1:0] src);
    return uses & wr & (dest == src) & (src != '0);
  endfunction

  assign exe_rs = src_match(hz.id_uses_rs, exe_wr_q, exe_dest_q, hz.id_rs);
  assign exe_rt = src_match(hz.id_uses_rt, exe_wr_q, exe_dest_q, hz.id_rt);
  assign mem_rs = src_match(hz.id_uses_rs, mem_wr_q, mem_dest_q, hz.id_rs);
  assign mem_rt = src_match(hz.id_uses_rt, mem_wr_q, mem_dest_q, hz.id_rt);

  // A load in EXE cannot forward yet; fall through to MEM (or regfile).
  always_comb begin
    sel_a = 2'd0;
    if (exe_rs && !exe_ld_q) begin
      sel_a = 2'd1;
    end else if (mem_rs) begin
      sel_a = 2'd2;
    end
  end

  always_comb begin
    sel_b = 2'd0;
    if (exe_rt && !exe_ld_q) begin
      sel_b = 2'd1;
    end else if (mem_rt) begin
      sel_b = 2'd2;
    end
  end

  assign load_use = hz.id_valid & (exe_rs | exe_rt) & exe_ld_q;
  assign sys_trig = hz.id_valid & hz.id_syscall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fsm_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sys_trig) begin
          fsm_stall = 1'b1;
          cnt_d     = DrainLoad;
          state_d   = SkipDrain ? StSignal : StDrain;
        end
      end
      StDrain: begin
        fsm_stall = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StSignal;
        end
      end
      StSignal: begin
        fsm_stall = 1'b1;
        state_d   = StRelease;
      end
      StRelease: begin
        // Syscall moves into EXE now; a held id_syscall must not retrigger.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Gated by RESET so outputs read zero while reset is held.
  assign stall       = ~RESET & (fsm_stall | load_use);
  assign sys_pulse_d = (state_q == StSignal);

  always_comb begin
    mem_dest_d = exe_dest_q;
    mem_wr_d   = exe_wr_q;
    mem_ld_d   = exe_ld_q;
    exe_dest_d = '0;
    exe_wr_d   = 1'b0;
    exe_ld_d   = 1'b0;
    if (hz.id_valid && !stall) begin
      exe_dest_d = hz.id_dest;
      exe_wr_d   = hz.id_reg_write;
      exe_ld_d   = hz.id_mem_read;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sys_pulse_q <= 1'b0;
      exe_dest_q  <= '0;
      exe_wr_q    <= 1'b0;
      exe_ld_q    <= 1'b0;
      mem_dest_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_ld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_pulse_q <= sys_pulse_d;
      exe_dest_q  <= exe_dest_d;
      exe_wr_q    <= exe_wr_d;
      exe_ld_q    <= exe_ld_d;
      mem_dest_q  <= mem_dest_d;
      mem_wr_q    <= mem_wr_d;
      mem_ld_q    <= mem_ld_d;
    end
  end

`ifdef HAZ_PERF_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_cycles = stall_cnt_q;
`else
  assign hz.stall_cycles = 32'd0;
`endif

  assign hz.sel_a     = sel_a;
  assign hz.sel_b     = sel_b;
  assign hz.stall     = stall;
  assign hz.bubble    = stall;
  assign hz.sys_pulse = sys_pulse_q;

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Directed bench for id_hazard_scheduler: forwarding, load-use, register 0,
// EXE priority, syscall sequencing, reset mid-sequence and the stall counter.
module tb_id_hazard_scheduler;

`ifdef HAZ_PERF_COUNT_EN
  localparam logic [31:0] ExpStallCycles = 32'd3;
`else
  localparam logic [31:0] ExpStallCycles = 32'd0;
`endif

  logic CLK;
  logic RESET;
  int   checks;
  int   passed;
  int   failed;

  id_hazard_scheduler_if #(.REG_BITS(5)) hz ();

  id_hazard_scheduler #(
    .SYS_DRAIN_CYCLES(4),
    .REG_BITS        (5)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .hz   (hz)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic wr, input logic ld, input logic sys);
    hz.id_valid     = v;
    hz.id_rs        = rs;
    hz.id_rt        = rt;
    hz.id_uses_rs   = urs;
    hz.id_uses_rt   = urt;
    hz.id_dest      = dest;
    hz.id_reg_write = wr;
    hz.id_mem_read  = ld;
    hz.id_syscall   = sys;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    failed = 0;

    // Reset held with a syscall presented: everything must read zero.
    RESET = 1'b1;
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    chk("rst_stall", 32'(hz.stall), 32'd0);
    chk("rst_bubble", 32'(hz.bubble), 32'd0);
    chk("rst_pulse", 32'(hz.sys_pulse), 32'd0);
    chk("rst_sel_a", 32'(hz.sel_a), 32'd0);
    chk("rst_cycles", hz.stall_cycles, 32'd0);
    step();
    RESET = 1'b0;
    idle();
    step();

    // lw $8 then add rs=8: one-cycle load-use stall, then MEM forward.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("lw_nostall", 32'(hz.stall), 32'd0);
    step();
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("lu_stall", 32'(hz.stall), 32'd1);
    chk("lu_bubble", 32'(hz.bubble), 32'd1);
    chk("lu_sel_a", 32'(hz.sel_a), 32'd0);
    step();
    @(negedge CLK);
    chk("lu2_stall", 32'(hz.stall), 32'd0);
    chk("lu2_sel_a", 32'(hz.sel_a), 32'd2);
    step();

    // add $9 then beq $9,$9: both operands from EXE.
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("beq_sel_a", 32'(hz.sel_a), 32'd1);
    chk("beq_sel_b", 32'(hz.sel_b), 32'd1);
    chk("beq_stall", 32'(hz.stall), 32'd0);
    step();

    // Load targeting $0, consumer reads $0: never a match.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk("r0_sel_a", 32'(hz.sel_a), 32'd0);
    chk("r0_stall", 32'(hz.stall), 32'd0);
    step();

    // EXE and MEM both write $5: EXE wins; then MEM-only forward.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("prio_sel_b", 32'(hz.sel_b), 32'd1);
    step();
    drive(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("mem_sel_b", 32'(hz.sel_b), 32'd2);
    step();

    // Load in EXE but decode not valid: no stall.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("inv_stall", 32'(hz.stall), 32'd0);
    step();
    idle();
    step();
    step();

    // Syscall: 5 stalled cycles, pulse in cycle 6 with stall released.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    chk("sys_c1_stall", 32'(hz.stall), 32'd1);
    chk("sys_c1_bubble", 32'(hz.bubble), 32'd1);
    chk("sys_c1_pulse", 32'(hz.sys_pulse), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      step();
      @(negedge CLK);
      chk($sformatf("sys_c%0d_stall", i), 32'(hz.stall), 32'd1);
      chk($sformatf("sys_c%0d_pulse", i), 32'(hz.sys_pulse), 32'd0);
    end
    step();
    @(negedge CLK);
    chk("sys_c6_stall", 32'(hz.stall), 32'd0);
    chk("sys_c6_bubble", 32'(hz.bubble), 32'd0);
    chk("sys_c6_pulse", 32'(hz.sys_pulse), 32'd1);

    // Back-to-back syscall restarts the whole sequence.
    step();
    @(negedge CLK);
    chk("b2b_c1_stall", 32'(hz.stall), 32'd1);
    chk("b2b_c1_pulse", 32'(hz.sys_pulse), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      step();
      @(negedge CLK);
      chk($sformatf("b2b_c%0d_stall", i), 32'(hz.stall), 32'd1);
    end
    step();
    @(negedge CLK);
    chk("b2b_c6_stall", 32'(hz.stall), 32'd0);
    chk("b2b_c6_pulse", 32'(hz.sys_pulse), 32'd1);
    step();
    idle();
    @(negedge CLK);
    chk("b2b_c7_pulse", 32'(hz.sys_pulse), 32'd0);
    chk("b2b_c7_stall", 32'(hz.stall), 32'd0);
    step();

    // Reset during DRAIN: immediate zero outputs, sequence abandoned.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    chk("mr_trig_stall", 32'(hz.stall), 32'd1);
    step();
    RESET = 1'b1;
    #1;
    chk("mr_stall", 32'(hz.stall), 32'd0);
    chk("mr_bubble", 32'(hz.bubble), 32'd0);
    chk("mr_cycles", hz.stall_cycles, 32'd0);
    idle();
    step();
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("mr_post%0d_pulse", i), 32'(hz.sys_pulse), 32'd0);
      chk($sformatf("mr_post%0d_stall", i), 32'(hz.stall), 32'd0);
      step();
    end

    // Three load-use stalls after reset.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
      @(negedge CLK);
      chk($sformatf("pc%0d_lw_stall", k), 32'(hz.stall), 32'd0);
      step();
      drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      chk($sformatf("pc%0d_lu_stall", k), 32'(hz.stall), 32'd1);
      step();
      @(negedge CLK);
      chk($sformatf("pc%0d_fwd_sel_a", k), 32'(hz.sel_a), 32'd2);
      step();
    end
    idle();
    @(negedge CLK);
    chk("perf_cycles", hz.stall_cycles, ExpStallCycles);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
